cpu_bus_master: RTL
===================

CPU_BUS_MASTER -- requirements
Module: cpu_bus_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning the maximum WAIT-state cycles before an error response.
REQ-002 clk  input  1  system clock, all state on posedge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  CPU request present.
REQ-005 req_ready  output  1  block accepts a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  0 = byte, 1 = half, 2 = word; 3 = illegal.
REQ-008 req_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, LSB-aligned.
REQ-011 resp_valid  output  1  one-cycle response strobe.
REQ-012 resp_err  output  1  error flag, qualified by resp_valid.
REQ-013 resp_rdata  output  32  extended load data, qualified by resp_valid; 0 for stores and errors.
REQ-014 address  output  32  bus byte address.
REQ-015 wdata  output  32  bus write data.
REQ-016 WLEN  output  2  bus opcode: 00 RD32, 01 WR8, 10 WR16, 11 WR32.
REQ-017 EN_N  output  1  active-low bus start strobe.
REQ-018 READY  input  1  registered bus idle flag.
REQ-019 rdata  input  32  bus read data, valid when READY returns high.

Function
REQ-020 SHALL implement states IDLE, ISSUE, WAIT, RESP.
REQ-021 In IDLE, req_ready SHALL equal READY; a request SHALL be accepted when req_valid && req_ready at posedge.
REQ-022 On acceptance SHALL latch all req_* fields; address, wdata and WLEN SHALL then be held constant until RESP completes.
REQ-023 Alignment check: half with req_addr[0]=1, word with req_addr[1:0]!=0, and req_size=3 are misaligned or illegal.
REQ-024 A misaligned or illegal request SHALL go IDLE->RESP with resp_err=1, and EN_N SHALL never assert.
REQ-025 Opcode mapping: any load -> RD32; byte store -> WR8; half store -> WR16; word store -> WR32.
REQ-026 address SHALL be req_addr unmodified; wdata SHALL be req_wdata unmodified.
REQ-027 ISSUE SHALL last exactly one cycle with EN_N=0; EN_N SHALL be 1 in every other state.
REQ-028 ISSUE SHALL always go to WAIT, and the WAIT cycle counter SHALL reset to 0.
REQ-029 WAIT SHALL ignore READY in its first cycle, because the bus drops READY at the edge ending ISSUE.
REQ-030 From the second WAIT cycle on, READY=1 SHALL capture rdata and go to RESP with resp_err=0.
REQ-031 If the counter reaches TIMEOUT-1 without READY, WAIT SHALL go to RESP with resp_err=1.
REQ-032 RESP SHALL last one cycle with resp_valid=1, then return to IDLE; req_ready SHALL be 0 in ISSUE, WAIT and RESP.
REQ-033 Byte load SHALL use rdata[7:0] when addr[0]=0, else rdata[15:8], extended to 32 bits per req_unsigned.
REQ-034 Half load SHALL use rdata[15:0], extended per req_unsigned; word load SHALL use rdata[31:0].
REQ-035 Latency, bus not stalled: accept edge -> ISSUE -> WAIT (bus cycles + 1) -> RESP.
REQ-036 Back-to-back operation: a new request SHALL be accepted no earlier than the IDLE cycle after RESP, and only with READY=1.

Reset
REQ-037 Assertion of reset_n=0 SHALL immediately force state IDLE, EN_N=1, WLEN=0, address=0, wdata=0.
REQ-038 The same reset SHALL immediately force resp_valid=0, resp_err=0, resp_rdata=0 and counter=0.
REQ-039 Reset during ISSUE or WAIT SHALL abandon the transaction with no response.
REQ-040 After reset, no request SHALL be accepted until READY=1, so any bus transaction still in flight drains first.

Verification
REQ-041 Load byte, addr=0x3, unsigned=0, bus rdata=0x1234_80FF -> resp_rdata=0xFFFF_FF80, err=0, one EN_N pulse with WLEN=00.
REQ-042 Store word, addr=0x8, wdata=0xDEADBEEF -> EN_N low exactly 1 cycle, WLEN=11, address/wdata stable until resp_valid.
REQ-043 Load half, addr=0x5 -> resp_valid with err=1 one cycle after acceptance, EN_N stays 1.
REQ-044 Bus holds READY=0 indefinitely, TIMEOUT=16 -> resp_err=1 exactly 16 WAIT cycles after ISSUE.
REQ-045 Two back-to-back requests (load half unsigned addr=0x2 with rdata[15:0]=0x8001, then store byte) -> first resp_rdata=0x0000_8001; second EN_N pulse only after READY=1.
REQ-046 reset_n pulsed low during WAIT -> outputs reach reset values asynchronously, no resp_valid, next request waits for READY=1.

Source files
------------

// File: rtl/cpu_bus_master.sv
// CPU load/store adapter onto a strobed bus with a registered READY idle flag.
// One transaction in flight. Loads are lane-selected and extended on return.
module cpu_bus_master #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] address,
  output logic [31:0] wdata,
  output logic [1:0]  WLEN,
  output logic        EN_N,
  input  logic        READY,
  input  logic [31:0] rdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t          state;
  logic [CW-1:0]   wait_cnt;
  logic            lat_we;
  logic [1:0]      lat_size;
  logic            lat_uns;
  logic            bad_req;

  function automatic logic [1:0] opcode(input logic we, input logic [1:0] size);
    logic [1:0] op;
    op = 2'b00;
    if (we) begin
      case (size)
        2'd0:    op = 2'b01;
        2'd1:    op = 2'b10;
        default: op = 2'b11;
      endcase
    end
    return op;
  endfunction

  // Byte lane follows addr[0] only; the bus always returns the aligned halfword.
  function automatic logic [31:0] load_extend(input logic [31:0] d, input logic [1:0] size,
                                              input logic uns, input logic a0);
    logic [7:0]  lane;
    logic [31:0] res;
    lane = a0 ? d[15:8] : d[7:0];
    case (size)
      2'd0:    res = uns ? {24'd0, lane} : {{24{lane[7]}}, lane};
      2'd1:    res = uns ? {16'd0, d[15:0]} : {{16{d[15]}}, d[15:0]};
      default: res = d;
    endcase
    return res;
  endfunction

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    bad_req = 1'b0;
    case (req_size)
      2'd1:    bad_req = req_addr[0];
      2'd2:    bad_req = |req_addr[1:0];
      2'd3:    bad_req = 1'b1;
      default: bad_req = 1'b0;
    endcase
  end

  assign req_ready = (state == ST_IDLE) && READY;

  // NOTE: sequential state uses non-blocking assignments only; reset clears every register,
  // since the bus-facing outputs must drop to idle values the moment reset_n falls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      lat_we     <= 1'b0;
      lat_size   <= 2'd0;
      lat_uns    <= 1'b0;
      address    <= '0;
      wdata      <= '0;
      WLEN       <= 2'b00;
      EN_N       <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            address  <= req_addr;
            wdata    <= req_wdata;
            WLEN     <= opcode(req_we, req_size);
            lat_we   <= req_we;
            lat_size <= req_size;
            lat_uns  <= req_unsigned;
            if (bad_req) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state <= ST_ISSUE;
              EN_N  <= 1'b0;
            end
          end
        end
        ST_ISSUE: begin
          state    <= ST_WAIT;
          EN_N     <= 1'b1;
          wait_cnt <= '0;
        end
        ST_WAIT: begin
          // READY is stale in the first WAIT cycle: the bus only drops it at the ISSUE edge.
          if ((wait_cnt != '0) && READY) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= lat_we ? 32'd0 : load_extend(rdata, lat_size, lat_uns, address[0]);
          end else if (wait_cnt == CNT_LAST) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          state      <= ST_IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
